pixel_fetch_sequencer: RTL and testbench

//  Sequences a full-image scan through the grayscale fetch block: steps pixel_no 0..NUM_PIXELS-1,

---
 rtl/pixel_fetch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pixel_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_sequencer.sv
// Image-pass sequencer: walks pixel_no through the image, handshakes with the grayscale fetch
// block and streams each pixel out over valid/ready. Optional macro: PFS_ZERO_SKIP_EN.
module pixel_fetch_sequencer #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] pixel_no_o,
    output logic              grayscale_fetch_o,
    input  logic              grayscale_fetched_i,
    input  logic [DATA_W-1:0] gray_scale_i,
    output logic              px_valid_o,
    input  logic              px_ready_i,
    output logic [DATA_W-1:0] px_data_o,
    output logic [ADDR_W-1:0] px_idx_o,
    output logic              px_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_timeout_o
);

    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_GAP     = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pixel_no_q, pixel_no_d;
    logic [DATA_W-1:0] px_data_q, px_data_d;
    logic [ADDR_W-1:0] px_idx_q, px_idx_d;
    logic              px_last_q, px_last_d;
    logic              px_valid_q, px_valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`ifdef PFS_ZERO_SKIP_EN
    logic              skip_q, skip_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pixel_no_q <= '0;
            px_data_q  <= '0;
            px_idx_q   <= '0;
            px_last_q  <= 1'b0;
            px_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
`ifdef PFS_ZERO_SKIP_EN
            skip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pixel_no_q <= pixel_no_d;
            px_data_q  <= px_data_d;
            px_idx_q   <= px_idx_d;
            px_last_q  <= px_last_d;
            px_valid_q <= px_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
`ifdef PFS_ZERO_SKIP_EN
            skip_q     <= skip_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pixel_no_d = pixel_no_q;
        px_data_d  = px_data_q;
        px_idx_d   = px_idx_q;
        px_last_d  = px_last_q;
        px_valid_d = px_valid_q;
        busy_d     = busy_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
`ifdef PFS_ZERO_SKIP_EN
        skip_d     = skip_q;
`endif
        if (state_q == S_IDLE) begin
            // abort in the same cycle cancels the start request
            if (start_i && !abort_i) begin
                pixel_no_d = '0;
                busy_d     = 1'b1;
                err_d      = 1'b0;
                tmo_d      = '0;
                state_d    = S_FETCH;
            end
        end else if (abort_i) begin
            state_d    = S_IDLE;
            px_valid_d = 1'b0;
            busy_d     = 1'b0;
            tmo_d      = '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (grayscale_fetched_i) begin
                        px_data_d = gray_scale_i;
                        px_idx_d  = pixel_no_q;
                        px_last_d = (pixel_no_q == LAST_IDX);
`ifdef PFS_ZERO_SKIP_EN
                        skip_d    = (gray_scale_i == '0) && (pixel_no_q != LAST_IDX);
`endif
                        tmo_d     = '0;
                        state_d   = S_GAP;
                    end else if (tmo_q == TMO_MAX) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        tmo_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_GAP: begin
`ifdef PFS_ZERO_SKIP_EN
                    if (skip_q) begin
                        pixel_no_d = pixel_no_q + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end else begin
                        px_valid_d = 1'b1;
                        state_d    = S_PRESENT;
                    end
`else
                    px_valid_d = 1'b1;
                    state_d    = S_PRESENT;
`endif
                end
                S_PRESENT: begin
                    if (px_ready_i) begin
                        px_valid_d = 1'b0;
                        if (px_last_q) begin
                            state_d = S_DONE;
                        end else begin
                            pixel_no_d = pixel_no_q + ADDR_W'(1);
                            state_d    = S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign pixel_no_o        = pixel_no_q;
    assign grayscale_fetch_o = (state_q == S_FETCH);
    assign px_valid_o        = px_valid_q;
    assign px_data_o         = px_data_q;
    assign px_idx_o          = px_idx_q;
    assign px_last_o         = px_last_q;
    assign busy_o            = busy_q;
    assign done_o            = (state_q == S_DONE);
    assign err_timeout_o     = err_q;

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Bench for pixel_fetch_sequencer: single-cycle vector table plus multi-cycle pass sequences.
module tb_pixel_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, ready = 1'b1;
    logic        man_fetched = 1'b0;
    logic [15:0] man_gray = '0;
    logic        model_en = 1'b0;
    logic        img_zero = 1'b0;
    logic [1:0]  fcnt;

    logic [9:0]  pixel_no, px_idx;
    logic [15:0] gray, px_data;
    logic        fetch, fetched, px_valid, px_last, busy, done, err;

    int total = 0, passed = 0;

    always #5 clk = ~clk;

    pixel_fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .pixel_no_o(pixel_no), .grayscale_fetch_o(fetch),
        .grayscale_fetched_i(fetched), .gray_scale_i(gray),
        .px_valid_o(px_valid), .px_ready_i(ready), .px_data_o(px_data),
        .px_idx_o(px_idx), .px_last_o(px_last), .busy_o(busy),
        .done_o(done), .err_timeout_o(err)
    );

    // Fetch block model: pulses fetched on the third consecutive cycle of fetch.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) fcnt <= '0;
        else        fcnt <= (fetch && !fetched) ? fcnt + 2'd1 : 2'd0;

    assign fetched = model_en ? (fetch && fcnt == 2'd2) : man_fetched;
    assign gray = !model_en ? man_gray :
                  img_zero  ? ((pixel_no == 10'd0) ? 16'h0055 :
                               (pixel_no == 10'd783) ? 16'h00AA : 16'h0000)
                            : {8'h00, pixel_no[7:0]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        start, abort, fetched, ready;
        logic [15:0] gray;
        logic        e_fetch, e_valid, e_busy, e_done, e_err, e_last;
        logic [9:0]  e_pn, e_idx;
        logic [15:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic s, a, f, r, input logic [15:0] g,
                                input logic ef, ev, eb, ed, ee, el,
                                input logic [9:0] pn, idx, input logic [15:0] d);
        vec_t v;
        v.start = s; v.abort = a; v.fetched = f; v.ready = r; v.gray = g;
        v.e_fetch = ef; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_err = ee;
        v.e_last = el; v.e_pn = pn; v.e_idx = idx; v.e_data = d;
        return v;
    endfunction

    function automatic logic [63:0] pack_act();
        return {22'd0, fetch, px_valid, busy, done, err, px_last, pixel_no, px_idx, px_data};
    endfunction

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    vec_t vt[14];
    int cyc, beats, seq_err, last_cnt, last_cyc, done_cyc, bp_err, n;
    logic seen;
    logic [15:0] hold_d;
    logic [9:0]  hold_i;

    initial begin
        //          st ab fe rd gray      fe va bu dn er la pn  idx data
        vt[0]  = mk(0, 0, 0, 1, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        vt[1]  = mk(1, 1, 0, 1, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        vt[2]  = mk(1, 0, 0, 1, 16'h0,    1, 0, 1, 0, 0, 0, 0, 0, 16'h0);
        vt[3]  = mk(0, 0, 0, 1, 16'h0,    1, 0, 1, 0, 0, 0, 0, 0, 16'h0);
        vt[4]  = mk(0, 0, 1, 1, 16'h1234, 0, 0, 1, 0, 0, 0, 0, 0, 16'h1234);
        vt[5]  = mk(0, 0, 1, 1, 16'hFFFF, 0, 1, 1, 0, 0, 0, 0, 0, 16'h1234);
        vt[6]  = mk(0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 0, 0, 0, 16'h1234);
        vt[7]  = mk(1, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 0, 0, 0, 16'h1234);
        vt[8]  = mk(0, 0, 0, 1, 16'h0,    1, 0, 1, 0, 0, 0, 1, 0, 16'h1234);
        vt[9]  = mk(0, 0, 1, 1, 16'hBEEF, 0, 0, 1, 0, 0, 0, 1, 1, 16'hBEEF);
        vt[10] = mk(0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 0, 1, 1, 16'hBEEF);
        vt[11] = mk(0, 1, 0, 1, 16'h0,    0, 0, 0, 0, 0, 0, 1, 1, 16'hBEEF);
        vt[12] = mk(1, 0, 0, 1, 16'h0,    1, 0, 1, 0, 0, 0, 0, 1, 16'hBEEF);
        vt[13] = mk(0, 1, 1, 1, 16'h7777, 0, 0, 0, 0, 0, 0, 0, 1, 16'hBEEF);

        // reset
        repeat (3) @(negedge clk);
        chk("reset_outputs", pack_act(), 64'd0);
        rst_n = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (fetch || busy || px_valid || done || err) n++;
        end
        chk("idle_quiet", 64'(n), 64'd0);

        // single-cycle vectors
        for (int i = 0; i < 14; i++) begin
            start = vt[i].start; abort = vt[i].abort; man_fetched = vt[i].fetched;
            ready = vt[i].ready; man_gray = vt[i].gray;
            @(negedge clk);
            chk($sformatf("vec%0d", i), pack_act(),
                {22'd0, vt[i].e_fetch, vt[i].e_valid, vt[i].e_busy, vt[i].e_done,
                 vt[i].e_err, vt[i].e_last, vt[i].e_pn, vt[i].e_idx, vt[i].e_data});
        end
        start = 0; abort = 0; man_fetched = 0; ready = 1;

`ifndef PFS_ZERO_SKIP_EN
        // full pass, ready always high
        model_en = 1'b1;
        beats = 0; seq_err = 0; last_cnt = 0; last_cyc = 0; done_cyc = 0; seen = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (!seen && cyc < 6000) begin
            if (px_valid && ready) begin
                if (px_idx != 10'(beats) || px_data != {8'h00, px_idx[7:0]}) seq_err++;
                if (px_last) begin
                    last_cnt++;
                    last_cyc = cyc;
                    if (px_idx != 10'd783) seq_err++;
                end
                beats++;
            end
            if (done) begin seen = 1; done_cyc = cyc; end
            else begin @(negedge clk); cyc++; end
        end
        chk("full_done_seen", 64'(seen), 64'd1);
        chk("full_beats", 64'(beats), 64'd784);
        chk("full_seq_err", 64'(seq_err), 64'd0);
        chk("full_last_cnt", 64'(last_cnt), 64'd1);
        chk("full_done_cyc", 64'(done_cyc), 64'd3921);
        chk("done_after_last", 64'(done_cyc - last_cyc), 64'd1);
        @(negedge clk);
        chk("post_done", {62'd0, done, busy}, 64'd0);
`endif

        // backpressure on idx 5
        model_en = 1'b1; ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 0;
        while (!(px_valid && px_idx == 10'd5) && cyc < 200) begin @(negedge clk); cyc++; end
        chk("bp_reach_idx5", {63'd0, px_valid}, 64'd1);
        ready = 1'b0; hold_d = px_data; hold_i = px_idx; bp_err = 0;
        repeat (10) begin
            @(negedge clk);
            if (!px_valid || fetch || px_data != hold_d || px_idx != hold_i) bp_err++;
        end
        chk("bp_stable", 64'(bp_err), 64'd0);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {51'd0, px_valid, fetch, pixel_no}, {51'd0, 1'b0, 1'b1, 10'd6});
        do_abort();

        // fetch timeout
        model_en = 1'b0; man_fetched = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 0;
        while (fetch && n < 100) begin n++; @(negedge clk); end
        chk("tmo_fetch_cycles", 64'(n), 64'd15);
        chk("tmo_flags", {61'd0, err, busy, done}, {61'd0, 3'b100});
        n = 0;
        repeat (5) begin @(negedge clk); if (done || fetch) n++; end
        chk("tmo_quiet", 64'(n), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("tmo_cleared", {62'd0, err, busy}, {62'd0, 2'b01});
        do_abort();

        // abort at idx 100 coincident with fetched
        model_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 0;
        while (!(pixel_no == 10'd100 && fetched) && cyc < 1000) begin @(negedge clk); cyc++; end
        chk("ab_reach_100", {63'd0, fetched}, 64'd1);
        do_abort();
        chk("ab_idle", {50'd0, busy, fetch, px_valid, done, px_idx},
            {50'd0, 4'b0000, 10'd99});
        n = 0;
        repeat (5) begin @(negedge clk); if (done || px_valid || busy) n++; end
        chk("ab_quiet", 64'(n), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ab_restart", {50'd0, busy, fetch, 2'b00, pixel_no}, {50'd0, 4'b1100, 10'd0});
        do_abort();

        // asynchronous reset mid-pass
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midpass_reset", pack_act(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef PFS_ZERO_SKIP_EN
        // zero skipping: only first and last pixels are presented
        model_en = 1'b1; img_zero = 1'b1; ready = 1'b1;
        beats = 0; seq_err = 0; seen = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (!seen && cyc < 6000) begin
            if (px_valid) begin
                if (beats == 0 && (px_idx != 10'd0 || px_data != 16'h0055)) seq_err++;
                if (beats == 1 && (px_idx != 10'd783 || px_data != 16'h00AA || !px_last)) seq_err++;
                beats++;
            end
            if (done) seen = 1;
            else begin @(negedge clk); cyc++; end
        end
        chk("zs_done_seen", 64'(seen), 64'd1);
        chk("zs_beats", 64'(beats), 64'd2);
        chk("zs_values", 64'(seq_err), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
